// File: rtl/mem_responder.sv
// Memory-side responder: services held read/write requests from an internal
// word-organised RAM after WAIT_STATES cycles, with byte-lane steering for
// stores, lane extraction plus sign/zero extension for loads, and
// misaligned / fault reporting alongside the single-cycle completion pulse.
module mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_f3,
  output logic [31:0] mem_rdata,
  output logic        mem_complete,
  output logic        mem_misaligned,
  output logic        mem_fault
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [1:0]      lane_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;
  logic            we_q;

  logic [31:0] ram [MEM_WORDS];

  logic        req;
  logic [31:0] word_off;
  logic        req_fault;
  logic        req_misaligned;
  logic        access;
  logic        ram_we;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rword;
  logic [31:0] load_val;

  // Decode the incoming request's error conditions; fault outranks misalignment.
  always_comb begin
    req            = mem_read | mem_write;
    word_off       = (mem_addr - BASE_ADDR) >> 2;
    req_fault      = (mem_addr < BASE_ADDR) || (word_off >= MEM_WORDS) ||
                     (mem_f3[1:0] == 2'd3) || (mem_read && mem_write);
    req_misaligned = ((mem_f3[1:0] == 2'd1) && mem_addr[0]) ||
                     ((mem_f3[1:0] == 2'd2) && (mem_addr[1:0] != 2'b00));
  end

  // Lane steering for stores and lane extraction/extension for loads.
  always_comb begin
    access   = (state_q == StBusy) && req && (cnt_q == 4'd0);
    ram_we   = access && we_q;
    wdata_sh = wdata_q << {lane_q, 3'b000};
    rword    = ram[idx_q] >> {lane_q, 3'b000};
    case (f3_q[1:0])
      2'd0: begin
        be       = 4'b0001 << lane_q;
        load_val = f3_q[2] ? {24'h0, rword[7:0]} : {{24{rword[7]}}, rword[7:0]};
      end
      2'd1: begin
        be       = lane_q[1] ? 4'b1100 : 4'b0011;
        load_val = f3_q[2] ? {16'h0, rword[15:0]} : {{16{rword[15]}}, rword[15:0]};
      end
      default: begin
        be       = 4'b1111;
        load_val = rword;
      end
    endcase
  end

  // Byte-enabled RAM write; no reset so contents survive and map onto RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx_q][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Request FSM with registered completion, flags and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      idx_q          <= '0;
      lane_q         <= 2'b00;
      wdata_q        <= 32'h0;
      f3_q           <= 3'd0;
      we_q           <= 1'b0;
      mem_rdata      <= 32'h0;
      mem_complete   <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_fault      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            idx_q   <= word_off[IdxW-1:0];
            lane_q  <= mem_addr[1:0];
            wdata_q <= mem_wdata;
            f3_q    <= mem_f3;
            we_q    <= mem_write;
            if (req_fault || req_misaligned) begin
              // Errors skip the wait states entirely.
              state_q        <= StDone;
              mem_complete   <= 1'b1;
              mem_fault      <= req_fault;
              mem_misaligned <= !req_fault && req_misaligned;
              mem_rdata      <= 32'h0;
            end else begin
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (!req) begin
            // Request withdrawn by the core: drop it silently.
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q      <= StDone;
            mem_complete <= 1'b1;
            if (!we_q) mem_rdata <= load_val;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          mem_complete   <= 1'b0;
          mem_misaligned <= 1'b0;
          mem_fault      <= 1'b0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, hand-written abort/reset sequences
// and randomized traffic against a byte-addressed reference memory.
module tb_mem_responder;

  localparam int unsigned Words = 64;

  logic        clk;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  f3    [2];
  logic [31:0] rdata [2];
  logic        cmpl  [2];
  logic        mis   [2];
  logic        flt   [2];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mb [256];

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f;
    logic        chk_rd;
    logic [31:0] rd;
    logic        mis;
    logic        flt;
  } vec_t;

  vec_t tbl [17];

  mem_responder #(.MEM_WORDS(Words), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_f3(f3[0]), .mem_rdata(rdata[0]), .mem_complete(cmpl[0]),
    .mem_misaligned(mis[0]), .mem_fault(flt[0])
  );

  mem_responder #(.MEM_WORDS(Words), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_f3(f3[1]), .mem_rdata(rdata[1]), .mem_complete(cmpl[1]),
    .mem_misaligned(mis[1]), .mem_fault(flt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Drive one request, hold it until completion (scrambling the payload while
  // busy), then drop it and sample the pulse one cycle later.
  task automatic xact(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f,
                      output logic [31:0] rdv, output logic misv, output logic fltv,
                      output int lat, output logic after);
    bit done;
    @(posedge clk); #1;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; f3[d] = f;
    lat = 0; rdv = 32'h0; misv = 1'b0; fltv = 1'b0; done = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (cmpl[d]) begin
          lat = i; rdv = rdata[d]; misv = mis[d]; fltv = flt[d]; done = 1'b1;
        end else if (i >= 2) begin
          addr[d] = $urandom; wdata[d] = $urandom; f3[d] = 3'($urandom);
        end
      end
    end
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(negedge clk);
    after = cmpl[d];
  endtask

  task automatic run(input string nm, input int d, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                     input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_mis, input logic exp_flt);
    logic [31:0] rdv;
    logic        misv, fltv, after;
    int          lat, exp_lat;
    xact(d, r, w, a, wd, f, rdv, misv, fltv, lat, after);
    exp_lat = (exp_mis || exp_flt) ? 2 : ((d == 0) ? 4 : 6);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " misaligned"}, {31'h0, misv}, {31'h0, exp_mis});
    chk({nm, " fault"}, {31'h0, fltv}, {31'h0, exp_flt});
    chk({nm, " pulse"}, {31'h0, after}, 32'h0);
    if (chk_rd) chk({nm, " rdata"}, rdv, exp_rd);
  endtask

  initial begin
    logic        r, w, e_mis, e_flt;
    logic [31:0] a, wd, v;
    logic [2:0]  f;
    int          n;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3'd2, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h13,  32'h00000080, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h13,  32'h0,        3'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h13,  32'h0,        3'd4, 1'b1, 32'h00000080, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3'd2, 1'b1, 32'h80ADBEEF, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h11,  32'h0,        3'd1, 1'b1, 32'h0,        1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3'd2, 1'b1, 32'h80ADBEEF, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h100, 32'h0,        3'd2, 1'b1, 32'h0,        1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3'd3, 1'b1, 32'h0,        1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h10,  32'h12345678, 3'd2, 1'b1, 32'h0,        1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h10,  32'h0,        3'd2, 1'b1, 32'h80ADBEEF, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'h12,  32'h0000ABCD, 3'd1, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'h12,  32'h0,        3'd1, 1'b1, 32'hFFFFABCD, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h12,  32'h0,        3'd5, 1'b1, 32'h0000ABCD, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 32'h10,  32'h0,        3'd2, 1'b1, 32'hABCDBEEF, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 32'h11,  32'hFFFFFFFF, 3'd2, 1'b1, 32'h0,        1'b1, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; f3[d] = 3'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset rdata", rdata[d], 32'h0);
      chk("reset complete", {31'h0, cmpl[d]}, 32'h0);
      chk("reset misaligned", {31'h0, mis[d]}, 32'h0);
      chk("reset fault", {31'h0, flt[d]}, 32'h0);
    end
    rst = 1'b0;

    // Directed table on the single-wait-state instance.
    for (int k = 0; k < 17; k++) begin
      run($sformatf("tbl%0d", k), 0, tbl[k].r, tbl[k].w, tbl[k].a, tbl[k].wd, tbl[k].f,
          tbl[k].chk_rd, tbl[k].rd, tbl[k].mis, tbl[k].flt);
    end

    // Abort mid-wait on the three-wait-state instance.
    run("ws3 store20", 1, 1'b0, 1'b1, 32'h20, 32'h11112222, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    run("ws3 store24", 1, 1'b0, 1'b1, 32'h24, 32'h33334444, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h55555555; f3[1] = 3'd2;
    repeat (3) @(posedge clk);
    #1 wr[1] = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmpl[1]) n++;
    end
    chk("abort no completion", 32'(n), 32'h0);
    run("abort readback", 1, 1'b1, 1'b0, 32'h20, 32'h0, 3'd2, 1'b1, 32'h11112222, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a store's wait.
    @(posedge clk); #1;
    wr[1] = 1'b1; addr[1] = 32'h24; wdata[1] = 32'h99999999; f3[1] = 3'd2;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset rdata", rdata[1], 32'h0);
    chk("midreset complete", {31'h0, cmpl[1]}, 32'h0);
    chk("midreset fault", {31'h0, flt[1]}, 32'h0);
    wr[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run("reset readback", 1, 1'b1, 1'b0, 32'h24, 32'h0, 3'd2, 1'b1, 32'h33334444, 1'b0, 1'b0);

    // Fill RAM with known words so the reference memory is fully defined.
    for (int k = 0; k < int'(Words); k++) begin
      wd = $urandom;
      for (int b = 0; b < 4; b++) mb[4*k+b] = wd[8*b +: 8];
      run("fill", 0, 1'b0, 1'b1, 32'(4*k), wd, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    end

    // Random traffic against a byte-addressed reference memory.
    for (int t = 0; t < 300; t++) begin
      r = 1'($urandom_range(0, 1));
      w = !r;
      if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
      a  = $urandom_range(0, 32'h10F);
      f  = 3'($urandom_range(0, 7));
      wd = $urandom;
      n  = 1 << f[1:0];
      e_flt = (a >= 4 * Words) || (f[1:0] == 2'd3) || (r && w);
      e_mis = !e_flt && (((f[1:0] == 2'd1) && (a % 2 != 0)) ||
                         ((f[1:0] == 2'd2) && (a % 4 != 0)));
      v = 32'h0;
      if (!e_flt && !e_mis) begin
        if (w) begin
          for (int b = 0; b < n; b++) mb[a+b] = wd[8*b +: 8];
        end else begin
          for (int b = 0; b < n; b++) v = v | (32'(mb[a+b]) << (8 * b));
          if (f == 3'd0) v = {{24{v[7]}}, v[7:0]};
          if (f == 3'd1) v = {{16{v[15]}}, v[15:0]};
        end
      end
      run($sformatf("rand%0d", t), 0, r, w, a, wd, f, r || e_flt || e_mis, v, e_mis, e_flt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory request interface.
- The core holds mem_read or mem_write, the address, write data and funct3 stable until it sees mem_complete. The responder services the request from an internal word-organised RAM after a programmable number of wait states and returns one completion pulse.
- It performs byte-lane steering for stores and lane extraction with sign/zero extension for loads.
- It flags misaligned and out-of-range accesses back to the core's trap logic.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the internal RAM.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- WAIT_STATES, 1, extra cycles between request acceptance and completion (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mem_read  in  1  read request; held until mem_complete.
- mem_write  in  1  write request; held until mem_complete.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_f3  in  3  access funct3: [1:0] 0=byte, 1=half, 2=word, 3=illegal; [2]=1 means unsigned load.
- mem_rdata  out  32  load result, extended per mem_f3; valid while mem_complete=1, held afterwards.
- mem_complete  out  1  one-cycle completion pulse, registered.
- mem_misaligned  out  1  qualifies mem_complete: half with addr[0]=1, or word with addr[1:0]!=0.
- mem_fault  out  1  qualifies mem_complete: out of range, illegal size, or read and write both high.

Behaviour:
- Reset values: mem_rdata=0, mem_complete=0, mem_misaligned=0, mem_fault=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read or mem_write is high, latch addr, wdata, f3 and op, and evaluate errors.
  - Any error goes to DONE immediately; completion follows 1 cycle after acceptance, regardless of WAIT_STATES.
  - Otherwise load the counter with WAIT_STATES and go to BUSY.
- BUSY:
  - If mem_read and mem_write are both low (request withdrawn, e.g. an exception), abort to IDLE: no RAM write, no completion.
  - Else if counter==0, perform the access and go to DONE.
  - Else decrement the counter.
  - Changes to addr, data or f3 during BUSY are ignored; latched values are used.
- DONE:
  - mem_complete=1 for exactly this cycle; the error flags are valid in the same cycle. Next state is IDLE.
- Latency: a request sampled in IDLE at edge N gives mem_complete in the cycle after edge N+1+WAIT_STATES.
- Back-to-back requests: the core may present a new request in the cycle after DONE. IDLE accepts it, so there is no dead cycle beyond IDLE itself.
- Range check: idx=(mem_addr-BASE_ADDR)>>2, using 32-bit unsigned wraparound. The access faults if mem_addr<BASE_ADDR or idx>=MEM_WORDS.
- Error priority: mem_fault is checked before mem_misaligned, and only one flag is ever set.
- On any error: no RAM write and mem_rdata=0.
- Store lanes: byte goes to lane addr[1:0] (1 byte written); half goes to lanes {addr[1],0} (2 bytes); word writes all 4 bytes. Unselected bytes are unchanged.
- Load: shift the word right by 8*addr[1:0], then:
  - byte: sign-extend bit 7, or zero-extend if f3[2]=1;
  - half: sign-extend bit 15, or zero-extend if f3[2]=1;
  - word: no extension, f3[2] is ignored.
  - The read is registered into mem_rdata on the BUSY→DONE edge.
- Write and read are never simultaneous within one request. A load following a store to the same address observes the new data.
- Reset asserted mid-BUSY returns the FSM to IDLE asynchronously, no RAM write occurs, and the outputs return to their reset values.

Test Plan:
1. WAIT_STATES=1. Sequence: store word 32'hDEADBEEF at 0x10, then load word from 0x10 → mem_complete 3 cycles after each request is sampled; mem_rdata=32'hDEADBEEF.
2. Store byte 8'h80 at 0x13, then load byte signed (f3=0) → 32'hFFFFFF80. Then load byte unsigned (f3=4) → 32'h00000080. Finally load word → 32'h80ADBEEF, confirming the other lanes are unchanged.
3. Load half at 0x11 → mem_complete 1 cycle after acceptance, mem_misaligned=1, mem_rdata=0. A subsequent load word at 0x10 proves the RAM is unmodified.
4. Load word at BASE_ADDR+4*MEM_WORDS, f3=3, and mem_read together with mem_write → each gives mem_fault=1, mem_misaligned=0, mem_complete 1 cycle after acceptance.
5. WAIT_STATES=3. Start a store at 0x20 and drop mem_write after 2 BUSY cycles → no mem_complete; a load word at 0x20 returns the old value.
6. Assert rst during BUSY of a store → outputs return to 0 immediately, no write occurs, and the next request completes normally.
